// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared counter, edge- or centre-aligned, with
// double-buffered duty values that are applied atomically at the period boundary.
module pwm_multi #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mode,
   input  logic [CHANNELS-1:0] ch_en,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_val,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_start,
   output logic                update_pending,
   output logic [WIDTH-1:0]    cnt
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic                dir;
   logic                mode_act;
   logic [CHANNELS-1:0] en_act;
   logic [WIDTH-1:0]    shadow      [CHANNELS];
   logic [WIDTH-1:0]    active      [CHANNELS];

   logic                wr_ok;
   logic                terminal;
   logic [WIDTH-1:0]    cnt_nxt;
   logic                dir_nxt;
   logic [CHANNELS-1:0] en_nxt;
   logic [CHANNELS-1:0] pwm_nxt;
   logic [WIDTH-1:0]    next_shadow [CHANNELS];
   logic [WIDTH-1:0]    active_nxt  [CHANNELS];

   assign wr_ok    = wr_en && (int'({1'b0, wr_ch}) < CHANNELS);
   assign terminal = mode_act ? (dir && (cnt == WIDTH'(1))) : (cnt == MAX);

   always_comb begin
      cnt_nxt = cnt + WIDTH'(1);
      dir_nxt = dir;
      if (terminal) begin
         cnt_nxt = '0;
         dir_nxt = 1'b0;
      end else if (mode_act && !dir && (cnt == MAX)) begin
         cnt_nxt = cnt - WIDTH'(1);
         dir_nxt = 1'b1;
      end else if (dir) begin
         cnt_nxt = cnt - WIDTH'(1);
      end
   end

   // Outputs are computed from next-period state so that the first pwm_out
   // cycle of a new period coincides with period_start and cnt==0.
   always_comb begin
      en_nxt = terminal ? ch_en : en_act;
      for (int i = 0; i < CHANNELS; i++) begin
         next_shadow[i] = (wr_ok && (wr_ch == CH_W'(i))) ? wr_val : shadow[i];
         active_nxt[i]  = terminal ? next_shadow[i] : active[i];
         pwm_nxt[i]     = en_nxt[i] & (cnt_nxt < active_nxt[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt            <= '0;
         dir            <= 1'b0;
         mode_act       <= 1'b0;
         en_act         <= '0;
         pwm_out        <= '0;
         period_start   <= 1'b0;
         update_pending <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         cnt          <= cnt_nxt;
         dir          <= dir_nxt;
         en_act       <= en_nxt;
         pwm_out      <= pwm_nxt;
         period_start <= terminal;
         shadow       <= next_shadow;
         active       <= active_nxt;
         if (terminal) begin
            mode_act       <= mode;
            update_pending <= 1'b0;
         end else if (wr_ok) begin
            update_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi (WIDTH=4, CHANNELS=3): directed steps plus a random phase,
// every cycle compared against a period-position reference model.
module tb_pwm_multi;

   localparam int W    = 4;
   localparam int CH   = 3;
   localparam int MAXV = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mode;
   logic [CH-1:0] ch_en;
   logic          wr_en;
   logic [1:0]    wr_ch;
   logic [W-1:0]  wr_val;
   logic [CH-1:0] pwm_out;
   logic          period_start;
   logic          update_pending;
   logic [W-1:0]  cnt;

   pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .ch_en(ch_en),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_val(wr_val),
      .pwm_out(pwm_out), .period_start(period_start),
      .update_pending(update_pending), .cnt(cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: position within the period, plus applied/buffered settings.
   int          pos = 0;
   bit          mode_m = 0;
   bit [CH-1:0] en_m = '0;
   int          duty_m   [CH];
   int          shadow_m [CH];
   bit          pend_m = 0;
   bit          ps_m = 0;

   function automatic int cnt_of(input int p, input bit m);
      if (!m) return p;
      return (p <= MAXV) ? p : 2 * MAXV - p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int len;
      bit wr_ok;
      wr_ok = wr_en && (int'(wr_ch) < CH);
      if (!rst_n) begin
         pos = 0; mode_m = 0; en_m = '0; pend_m = 0; ps_m = 0;
         for (int i = 0; i < CH; i++) begin
            duty_m[i] = 0; shadow_m[i] = 0;
         end
      end else begin
         len = mode_m ? 2 * MAXV : MAXV + 1;
         if (wr_ok) shadow_m[int'(wr_ch)] = int'(wr_val);
         if (pos == len - 1) begin
            for (int i = 0; i < CH; i++) duty_m[i] = shadow_m[i];
            mode_m = mode; en_m = ch_en; pend_m = 0; pos = 0; ps_m = 1;
         end else begin
            pos++; ps_m = 0;
            if (wr_ok) pend_m = 1;
         end
      end
   endtask

   task automatic check_model();
      logic [CH-1:0] e;
      int c;
      c = cnt_of(pos, mode_m);
      for (int i = 0; i < CH; i++) e[i] = en_m[i] && (c < duty_m[i]);
      chk("cnt", 32'(cnt), 32'(c));
      chk("pwm_out", 32'(pwm_out), 32'(e));
      chk("period_start", 32'(period_start), 32'(ps_m));
      chk("update_pending", 32'(update_pending), 32'(pend_m));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
      wr_en = 1'b0;
   endtask

   task automatic wait_ps(input int limit);
      int n = 0;
      while (!period_start && n < limit) begin
         tick();
         n++;
      end
      chk("wait_period_start", 32'(period_start), 32'd1);
   endtask

   // Starts on a period_start cycle; optionally writes when cnt shows wr_at.
   task automatic run_period(input int ch, input int len, input int wr_at,
                             input int wr_c, input int wr_v, output int highs);
      highs = 0;
      for (int k = 0; k < len; k++) begin
         if (pwm_out[ch]) highs++;
         if (int'(cnt) == wr_at) begin
            wr_en = 1'b1; wr_ch = 2'(wr_c); wr_val = W'(wr_v);
         end
         tick();
      end
      chk("period_length", 32'(period_start), 32'd1);
   endtask

   initial begin
      int h;
      int n;
      rst_n = 1'b0; mode = 1'b0; ch_en = '0; wr_en = 1'b0; wr_ch = '0; wr_val = '0;
      for (int i = 0; i < CH; i++) begin
         duty_m[i] = 0; shadow_m[i] = 0;
      end
      tick();
      tick();
      chk("reset_cnt", 32'(cnt), 32'd0);
      chk("reset_pwm", 32'(pwm_out), 32'd0);

      // Edge mode, ch0 duty 5
      rst_n = 1'b1; ch_en = 3'b001;
      wr_en = 1'b1; wr_ch = 2'd0; wr_val = 4'd5;
      tick();
      chk("pending_after_write", 32'(update_pending), 32'd1);
      wait_ps(40);
      chk("pending_cleared", 32'(update_pending), 32'd0);
      chk("first_cycle_high", 32'(pwm_out[0]), 32'd1);
      run_period(0, 16, -1, 0, 0, h);
      chk("edge_duty5_highs", 32'(h), 32'd5);

      // Centre mode, ch1 duty 5
      mode = 1'b1; ch_en = 3'b010;
      wr_en = 1'b1; wr_ch = 2'd1; wr_val = 4'd5;
      tick();
      wait_ps(40);
      run_period(1, 30, -1, 0, 0, h);
      chk("centre_duty5_highs", 32'(h), 32'd9);

      // Back to edge mode; mid-period and terminal-cycle writes
      mode = 1'b0; ch_en = 3'b001;
      run_period(1, 30, -1, 0, 0, h);
      chk("centre_second_highs", 32'(h), 32'd9);
      run_period(0, 16, 3, 0, 10, h);
      chk("midwrite_current", 32'(h), 32'd5);
      run_period(0, 16, 15, 0, 2, h);
      chk("midwrite_next", 32'(h), 32'd10);
      run_period(0, 16, 15, 0, 0, h);
      chk("terminal_write_next", 32'(h), 32'd2);
      run_period(0, 16, 15, 0, 15, h);
      chk("duty0_highs", 32'(h), 32'd0);
      run_period(0, 16, -1, 0, 0, h);
      chk("duty15_highs", 32'(h), 32'd15);

      // Out-of-range channel index
      wr_en = 1'b1; wr_ch = 2'd3; wr_val = 4'd7;
      tick();
      chk("bad_ch_pending", 32'(update_pending), 32'd0);
      wait_ps(20);
      run_period(0, 16, -1, 0, 0, h);
      chk("bad_ch_no_change", 32'(h), 32'd15);

      // Mode switch and ch0 disable mid-period
      h = 0;
      for (int k = 0; k < 16; k++) begin
         if (pwm_out[0]) h++;
         if (k == 6) begin
            mode = 1'b1; ch_en = 3'b000;
         end
         tick();
      end
      chk("switch_current_highs", 32'(h), 32'd15);
      chk("switch_boundary", 32'(period_start), 32'd1);
      chk("switch_pwm0_low", 32'(pwm_out[0]), 32'd0);
      run_period(0, 30, -1, 0, 0, h);
      chk("disabled_highs", 32'(h), 32'd0);

      // Reset at cnt==7 with enabled, non-zero duties
      ch_en = 3'b111;
      tick();
      wait_ps(40);
      n = 0;
      while (int'(cnt) != 7 && n < 40) begin
         tick();
         n++;
      end
      chk("reach_cnt7", 32'(cnt), 32'd7);
      rst_n = 1'b0;
      tick();
      chk("midreset_cnt", 32'(cnt), 32'd0);
      chk("midreset_pwm", 32'(pwm_out), 32'd0);
      chk("midreset_pending", 32'(update_pending), 32'd0);
      rst_n = 1'b1; mode = 1'b0;
      h = 0;
      for (int k = 0; k < 32; k++) begin
         if (pwm_out != '0) h++;
         tick();
      end
      chk("after_reset_no_output", 32'(h), 32'd0);

      // Random phase
      for (int k = 0; k < 500; k++) begin
         rst_n  = ($urandom_range(199) != 0);
         wr_en  = ($urandom_range(3) == 0);
         wr_ch  = 2'($urandom_range(3));
         wr_val = 4'($urandom_range(15));
         if ($urandom_range(39) == 0) mode = ~mode;
         if ($urandom_range(29) == 0) ch_en = 3'($urandom_range(7));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
